// File: rtl/datapath_seq_if.sv
// Command/status bundle between the instruction controller (master) and datapath_seq (slave).
// mul_sel exists only when DATAPATH_SEQ_MUL_EN is defined.
interface datapath_seq_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic             busy;
  logic             done;
  logic [AW-1:0]    ra_addr;
  logic [AW-1:0]    rb_addr;
  logic [AW-1:0]    w_addr;
  logic             sel_A;
  logic             sel_imm;
  logic [11:0]      imm;
  logic [1:0]       shift_op;
  logic [SW-1:0]    shift_amt;
  logic [2:0]       ALU_op;
  logic             set_flags;
  logic             wb_en;
  logic             wb_sel;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] datapath_out;
  logic [3:0]       status_out;
`ifdef DATAPATH_SEQ_MUL_EN
  logic             mul_sel;
`endif

  modport master (
    output start, ra_addr, rb_addr, w_addr, sel_A, sel_imm, imm, shift_op, shift_amt,
           ALU_op, set_flags, wb_en, wb_sel, load_data,
`ifdef DATAPATH_SEQ_MUL_EN
           mul_sel,
`endif
    input  busy, done, datapath_out, status_out
  );

  modport slave (
    input  start, ra_addr, rb_addr, w_addr, sel_A, sel_imm, imm, shift_op, shift_amt,
           ALU_op, set_flags, wb_en, wb_sel, load_data,
`ifdef DATAPATH_SEQ_MUL_EN
           mul_sel,
`endif
    output busy, done, datapath_out, status_out
  );
endinterface

// File: rtl/datapath_seq.sv
// Self-sequenced datapath: regfile, barrel shifter, 8-op ALU, NZCV; one command runs READ->EXEC->WB.
// DATAPATH_SEQ_MUL_EN adds a 2-cycle multiply (EXEC2) selected by mul_sel with ALU_op=ADD.
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  datapath_seq_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_ORR = 3'b011,
                         OP_EOR = 3'b100, OP_MOV = 3'b101, OP_MVN = 3'b110, OP_CMP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC,
`ifdef DATAPATH_SEQ_MUL_EN
    S_EXEC2,
`endif
    S_WB
  } state_t;

  typedef struct packed {
    logic [AW-1:0] ra, rb, wa;
    logic          sel_a, sel_imm;
    logic [11:0]   imm;
    logic [1:0]    sh_op;
    logic [SW-1:0] sh_amt;
    logic [2:0]    op;
    logic          set_flags, wb_en, wb_sel;
`ifdef DATAPATH_SEQ_MUL_EN
    logic          mul_sel;
`endif
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_in;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [3:0]       nzcv_q;

  logic [WIDTH:0]        lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]      ror_w, sh_out, val_a, val_b, opb, alu_res, prod;
  logic [SW-1:0]         rot;
  logic [WIDTH:0]        sum_w;
  logic                  sh_c, is_sub, ov, alu_c, alu_v, is_mul;

  always_comb begin
    cmd_in           = '0;
    cmd_in.ra        = bus.ra_addr;
    cmd_in.rb        = bus.rb_addr;
    cmd_in.wa        = bus.w_addr;
    cmd_in.sel_a     = bus.sel_A;
    cmd_in.sel_imm   = bus.sel_imm;
    cmd_in.imm       = bus.imm;
    cmd_in.sh_op     = bus.shift_op;
    cmd_in.sh_amt    = bus.shift_amt;
    cmd_in.op        = bus.ALU_op;
    cmd_in.set_flags = bus.set_flags;
    cmd_in.wb_en     = bus.wb_en;
    cmd_in.wb_sel    = bus.wb_sel;
`ifdef DATAPATH_SEQ_MUL_EN
    cmd_in.mul_sel   = bus.mul_sel;
`endif
  end

`ifdef DATAPATH_SEQ_MUL_EN
  assign is_mul = cmd_q.mul_sel && (cmd_q.op == OP_ADD);
`else
  assign is_mul = 1'b0;
`endif

  // One spare bit beside B catches the last bit shifted out, which is the shifter carry.
  always_comb begin
    lsl_w = {1'b0, b_q} << cmd_q.sh_amt;
    lsr_w = {b_q, 1'b0} >> cmd_q.sh_amt;
    asr_w = $signed({b_q, 1'b0}) >>> cmd_q.sh_amt;
    rot   = SW'(32'(cmd_q.sh_amt) % WIDTH);
    ror_w = (b_q >> rot) | (b_q << (WIDTH - int'(rot)));
    sh_out = b_q;
    sh_c   = nzcv_q[1];
    if (cmd_q.sh_amt != '0) begin
      unique case (cmd_q.sh_op)
        2'b00:   begin sh_out = lsl_w[WIDTH-1:0]; sh_c = lsl_w[WIDTH];   end
        2'b01:   begin sh_out = lsr_w[WIDTH:1];   sh_c = lsr_w[0];       end
        2'b10:   begin sh_out = asr_w[WIDTH:1];   sh_c = asr_w[0];       end
        default: begin sh_out = ror_w;            sh_c = ror_w[WIDTH-1]; end
      endcase
    end
  end

  always_comb begin
    val_a  = cmd_q.sel_a ? '0 : a_q;
    val_b  = cmd_q.sel_imm ? {{(WIDTH-12){1'b0}}, cmd_q.imm} : sh_out;
    is_sub = (cmd_q.op == OP_SUB) || (cmd_q.op == OP_CMP);
    opb    = is_sub ? ~val_b : val_b;
    sum_w  = {1'b0, val_a} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
    ov     = (val_a[WIDTH-1] == opb[WIDTH-1]) && (sum_w[WIDTH-1] != val_a[WIDTH-1]);
    prod   = a_q * val_b;
    alu_c  = cmd_q.sel_imm ? 1'b0 : sh_c;
    alu_v  = nzcv_q[0];
    unique case (cmd_q.op)
      OP_AND:  alu_res = val_a & val_b;
      OP_ORR:  alu_res = val_a | val_b;
      OP_EOR:  alu_res = val_a ^ val_b;
      OP_MOV:  alu_res = val_b;
      OP_MVN:  alu_res = ~val_b;
      default: begin alu_res = sum_w[WIDTH-1:0]; alu_c = sum_w[WIDTH]; alu_v = ov; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
`ifdef DATAPATH_SEQ_MUL_EN
      S_EXEC:  state_d = is_mul ? S_EXEC2 : S_WB;
      S_EXEC2: state_d = S_WB;
`else
      S_EXEC:  state_d = S_WB;
`endif
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      nzcv_q  <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (bus.start) cmd_q <= cmd_in;
        S_READ: begin
          a_q <= rf_q[cmd_q.ra];
          b_q <= rf_q[cmd_q.rb];
        end
        S_EXEC: if (!is_mul) begin
          if (cmd_q.op != OP_CMP) c_q <= alu_res;
          if (cmd_q.set_flags) nzcv_q <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
        end
`ifdef DATAPATH_SEQ_MUL_EN
        S_EXEC2: begin
          c_q <= prod;
          if (cmd_q.set_flags) nzcv_q[3:2] <= {prod[WIDTH-1], prod == '0};
        end
`endif
        S_WB: if (cmd_q.wb_en && cmd_q.op != OP_CMP)
          rf_q[cmd_q.wa] <= cmd_q.wb_sel ? bus.load_data : c_q;
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_WB);
  assign bus.datapath_out = c_q;
  assign bus.status_out   = nzcv_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a register-level model predicts C/NZCV/regfile per command,
// a negedge compare process checks busy/done/C/NZCV every cycle, and literals pin key results.
module tb_datapath_seq;
  localparam int W = 32, N = 16;
  localparam logic [2:0] ADD = 0, SUB = 1, AND_ = 2, ORR = 3, EOR = 4, MOV = 5, MVN = 6, CMP = 7;
  localparam logic [1:0] LSL = 0, LSR = 1, ASR = 2, ROR = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_seq_if #(.WIDTH(W), .NREGS(N)) bus();
  datapath_seq #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]  ra, rb, wa;
    logic        sel_a, sel_imm;
    logic [11:0] imm;
    logic [1:0]  sop;
    logic [4:0]  amt;
    logic [2:0]  op;
    logic        sf, wb_en, wb_sel;
    logic [31:0] ld;
  } cmd_t;

  int checks = 0, failures = 0;
  logic [31:0] m_regs [N];
  logic [31:0] m_c;
  logic [3:0]  m_nzcv;
  bit exp_busy = 0, exp_done = 0, chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("done", 32'(bus.done), 32'(exp_done));
      check("datapath_out", bus.datapath_out, m_c);
      check("status_out", 32'(bus.status_out), 32'(m_nzcv));
    end
  end

  function automatic cmd_t mk(input logic [2:0] op, input int ra, input int rb, input int wa,
                              input bit sel_imm, input int imm, input logic [1:0] sop,
                              input int amt, input bit sf, input bit wb_en, input bit wb_sel,
                              input logic [31:0] ld, input bit sel_a);
    cmd_t c;
    c.op = op; c.ra = 4'(ra); c.rb = 4'(rb); c.wa = 4'(wa);
    c.sel_imm = sel_imm; c.imm = 12'(imm); c.sop = sop; c.amt = 5'(amt);
    c.sf = sf; c.wb_en = wb_en; c.wb_sel = wb_sel; c.ld = ld; c.sel_a = sel_a;
    return c;
  endfunction

  // Architectural effect of one command, straight from the ARM-style rules.
  task automatic model_exec(input cmd_t c, output logic [31:0] nc, output logic [3:0] nf,
                            output bit wr, output logic [31:0] wd);
    logic [31:0] a, b, vb, r;
    logic [32:0] s33;
    logic sc, cf, vf;
    longint sl;
    int n;
    a  = c.sel_a ? 32'd0 : m_regs[c.ra];
    b  = m_regs[c.rb];
    sc = m_nzcv[1];
    vb = b;
    n  = int'(c.amt);
    if (c.sel_imm) begin
      vb = {20'd0, c.imm}; sc = 1'b0;
    end else if (n != 0) begin
      case (c.sop)
        LSL: begin vb = b << n; sc = b[32-n]; end
        LSR: begin vb = b >> n; sc = b[n-1]; end
        ASR: begin vb = 32'($signed(b) >>> n); sc = b[n-1]; end
        default: begin vb = (b >> n) | (b << (32 - n)); sc = b[n-1]; end
      endcase
    end
    cf = sc;
    vf = m_nzcv[0];
    case (c.op)
      ADD: begin
        s33 = {1'b0, a} + {1'b0, vb}; r = s33[31:0]; cf = s33[32];
        sl = longint'($signed(a)) + longint'($signed(vb));
        vf = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      SUB, CMP: begin
        r = a - vb; cf = (a >= vb);
        sl = longint'($signed(a)) - longint'($signed(vb));
        vf = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      AND_: r = a & vb;
      ORR:  r = a | vb;
      EOR:  r = a ^ vb;
      MOV:  r = vb;
      default: r = ~vb;
    endcase
    nc = (c.op == CMP) ? m_c : r;
    nf = c.sf ? {r[31], r == 32'd0, cf, vf} : m_nzcv;
    wr = c.wb_en && (c.op != CMP);
    wd = c.wb_sel ? c.ld : nc;
  endtask

  task automatic drive(input cmd_t c);
    bus.ra_addr = c.ra; bus.rb_addr = c.rb; bus.w_addr = c.wa;
    bus.sel_A = c.sel_a; bus.sel_imm = c.sel_imm; bus.imm = c.imm;
    bus.shift_op = c.sop; bus.shift_amt = c.amt; bus.ALU_op = c.op;
    bus.set_flags = c.sf; bus.wb_en = c.wb_en; bus.wb_sel = c.wb_sel;
    bus.load_data = $urandom();
`ifdef DATAPATH_SEQ_MUL_EN
    bus.mul_sel = 1'b0;
`endif
  endtask

  task automatic scramble(input bit start_v);
    bus.start = start_v;
    bus.ra_addr = 4'($urandom()); bus.rb_addr = 4'($urandom()); bus.w_addr = 4'($urandom());
    bus.sel_A = 1'($urandom()); bus.sel_imm = 1'($urandom()); bus.imm = 12'($urandom());
    bus.shift_op = 2'($urandom()); bus.shift_amt = 5'($urandom()); bus.ALU_op = 3'($urandom());
    bus.set_flags = 1'($urandom()); bus.wb_en = 1'($urandom()); bus.wb_sel = 1'($urandom());
    bus.load_data = $urandom();
  endtask

  // Start accepted at edge 0; done expected in cycle 3; back in IDLE afterwards.
  task automatic run(input cmd_t c, input bit hold);
    logic [31:0] nc, wd;
    logic [3:0] nf;
    bit wr;
    @(negedge clk);
    drive(c);
    bus.start = 1'b1;
    @(posedge clk); #1;
    model_exec(c, nc, nf, wr, wd);
    exp_busy = 1;
    scramble(hold);
    @(posedge clk); #1;
    scramble(hold);
    @(posedge clk); #1;
    m_c = nc; m_nzcv = nf; exp_done = 1;
    scramble(hold);
    bus.load_data = c.ld;
    @(posedge clk); #1;
    exp_busy = 0; exp_done = 0;
    bus.start = 1'b0;
    bus.load_data = $urandom();
    if (wr) m_regs[c.wa] = wd;
  endtask

  task automatic read_chk(input int r, input logic [31:0] exp, input string name);
    run(mk(MOV, 0, r, 0, 0, 0, LSL, 0, 0, 0, 0, 0, 0), 0);
    check(name, bus.datapath_out, exp);
  endtask

  cmd_t tbl [$];

  initial begin
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_c = '0; m_nzcv = '0;
    bus.start = 1'b0;
    drive(mk(MOV, 0, 0, 0, 0, 0, LSL, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", bus.datapath_out, 32'd0);
    check("rst_status", 32'(bus.status_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    run(mk(MOV, 0, 0, 1, 1, 5, LSL, 0, 0, 1, 0, 0, 0), 0);
    check("mov_r1", bus.datapath_out, 32'd5);
    run(mk(ADD, 1, 1, 2, 0, 0, LSL, 2, 1, 1, 0, 0, 0), 0);
    check("add_r2", bus.datapath_out, 32'd25);
    check("add_flags", 32'(bus.status_out), 32'b0000);

    run(mk(MOV, 0, 0, 3, 1, 3, LSL, 0, 0, 1, 0, 0, 0), 0);
    run(mk(MOV, 0, 0, 4, 1, 5, LSL, 0, 0, 1, 0, 0, 0), 0);
    run(mk(SUB, 3, 4, 5, 0, 0, LSL, 0, 1, 1, 0, 0, 0), 0);
    check("sub_r5", bus.datapath_out, 32'hFFFF_FFFE);
    check("sub_flags", 32'(bus.status_out), 32'b1000);

    run(mk(MOV, 0, 0, 6, 1, 0, LSL, 0, 0, 1, 1, 32'h7FFF_FFFF, 0), 0);
    run(mk(ADD, 6, 0, 6, 1, 1, LSL, 0, 1, 0, 0, 0, 0), 0);
    check("ovf_c", bus.datapath_out, 32'h8000_0000);
    check("ovf_flags", 32'(bus.status_out), 32'b1001);

    run(mk(CMP, 1, 0, 2, 1, 5, LSL, 0, 1, 1, 0, 0, 0), 0);
    check("cmp_flags", 32'(bus.status_out), 32'b0110);
    check("cmp_c_kept", bus.datapath_out, 32'h8000_0000);
    read_chk(2, 32'd25, "cmp_no_wb");

    run(mk(MOV, 0, 0, 7, 1, 0, LSL, 0, 0, 1, 1, 32'h8000_0000, 0), 0);
    run(mk(MOV, 0, 7, 8, 0, 0, ASR, 31, 1, 0, 0, 0, 0), 1);
    check("asr_c", bus.datapath_out, 32'hFFFF_FFFF);
    check("asr_cflag", 32'(bus.status_out[1]), 32'd0);
    check("asr_flags", 32'(bus.status_out), 32'b1000);
    repeat (3) @(posedge clk);

    tbl.push_back(mk(MOV, 0, 7, 0, 0, 0, LSR, 4, 1, 0, 0, 0, 0));
    tbl.push_back(mk(MOV, 0, 3, 0, 0, 0, ROR, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(MVN, 0, 3, 0, 0, 0, LSL, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(AND_, 5, 0, 12, 1, 12'hFF, LSL, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(ORR, 3, 4, 13, 0, 0, LSL, 3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(EOR, 1, 1, 11, 0, 0, LSL, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(MOV, 0, 0, 10, 1, 0, LSL, 0, 0, 1, 1, 32'h1234_5678, 0));
    tbl.push_back(mk(ADD, 10, 10, 10, 0, 0, LSL, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(MOV, 0, 10, 0, 0, 0, LSL, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(SUB, 1, 1, 14, 0, 0, LSL, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(MOV, 0, 7, 0, 0, 0, LSL, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(SUB, 12, 13, 15, 0, 0, LSR, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(MOV, 0, 4, 0, 0, 0, ASR, 1, 1, 0, 0, 0, 0));
    foreach (tbl[i]) run(tbl[i], 0);
    check("asr_pos_c", bus.datapath_out, 32'd2);
    check("asr_pos_flags", 32'(bus.status_out), 32'b0010);

    // Abort a write command in EXEC with an async pulse between clock edges.
    @(negedge clk);
    drive(mk(MOV, 0, 0, 9, 1, 7, LSL, 0, 1, 1, 0, 0, 0));
    bus.start = 1'b1;
    @(posedge clk); #1;
    exp_busy = 1; bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; chk_en = 0;
    #1;
    check("mid_rst_out", bus.datapath_out, 32'd0);
    check("mid_rst_status", 32'(bus.status_out), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_c = '0; m_nzcv = '0; exp_busy = 0; exp_done = 0;
    chk_en = 1;
    repeat (4) @(posedge clk);
    read_chk(9, 32'd0, "abort_no_wb");
    read_chk(1, 32'd0, "rst_cleared_r1");
    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
